fetch_decode_stage: RTL and testbench

Parametrised instruction fetch/decode front end for the processor datapath. It owns the PC, issues pipelined reads to an instruction memory with a valid/ready request and in-order response interface, and buffers returned words in an instruction queue. It decodes the queue head into register addresses, a sign-extended immediate and a format tag. Redirects (branch/jump) flush all in-flight and buffered instructions.

---
 rtl/fetch_decode_stage_pkg.sv | 85 ++++++++
 rtl/fetch_decode_stage_instr_queue.sv | 62 ++++++
 rtl/fetch_decode_stage.sv | 117 +++++++++++
 tb/tb_fetch_decode_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, format tags,
// queue sizing helpers and the combinational instruction decoder.
package fetch_decode_stage_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   // Immediates are carried as 32-bit sign-extended values; the top widens to XLEN.
   typedef struct packed {
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rw;
      logic [31:0] imm;
      fmt_e        fmt;
      logic        illegal;
   } dec_t;

   function automatic int iq_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int iq_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic dec_t decode(input logic [31:0] instr);
      dec_t d;
      d = '0;
      case (instr[6:0])
         OP_R: begin
            d.fmt = FMT_R;
            d.ra  = instr[19:15];
            d.rb  = instr[24:20];
            d.rw  = instr[11:7];
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            d.fmt = FMT_I;
            d.ra  = instr[19:15];
            d.rw  = instr[11:7];
            d.imm = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            d.fmt = FMT_S;
            d.ra  = instr[19:15];
            d.rb  = instr[24:20];
            d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            d.fmt = FMT_B;
            d.ra  = instr[19:15];
            d.rb  = instr[24:20];
            d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            d.fmt = FMT_U;
            d.rw  = instr[11:7];
            d.imm = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            d.fmt = FMT_J;
            d.rw  = instr[11:7];
            d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/fetch_decode_stage_instr_queue.sv
// Synchronous FIFO of {pc, instr} with a flush input; push and pop may
// coincide at any fill level, including full.
module instr_queue
   import fetch_decode_stage_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic [ADDR_W-1:0]          push_pc,
   input  logic [31:0]                push_instr,
   input  logic                       pop,
   output logic                       empty,
   output logic [iq_cnt_w(DEPTH)-1:0] count,
   output logic [ADDR_W-1:0]          head_pc,
   output logic [31:0]                head_instr
);

   localparam int PW = iq_ptr_w(DEPTH);
   localparam int CW = iq_cnt_w(DEPTH);

   logic [ADDR_W-1:0] pc_mem    [DEPTH];
   logic [31:0]       instr_mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     cnt;
   logic              do_push, do_pop;

   assign do_pop  = pop && (cnt != '0);
   assign do_push = push && ((cnt < CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

   assign empty      = (cnt == '0);
   assign count      = cnt;
   assign head_pc    = pc_mem[rd_ptr];
   assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch/decode front end: credit-limited pipelined fetch, in-order
// response buffering, redirect flush with stale-response discard, and decode.
module fetch_decode_stage
   import fetch_decode_stage_pkg::*;
#(
   parameter int                XLEN     = 64,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                IQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [31:0]       dec_instr,
   output logic [4:0]        dec_ra,
   output logic [4:0]        dec_rb,
   output logic [4:0]        dec_rw,
   output logic [XLEN-1:0]   dec_imm,
   output logic [2:0]        dec_fmt,
   output logic              dec_illegal
);

   localparam int CW = iq_cnt_w(IQ_DEPTH);

   logic [ADDR_W-1:0] pc, rsp_pc;
   logic [CW-1:0]     outstanding, discard, outstanding_nxt, discard_nxt, iq_count;
   logic [CW:0]       credit_used;
   logic              iq_empty, req_fire, rsp_keep, rsp_drop, pop;
   logic [ADDR_W-1:0] head_pc;
   logic [31:0]       head_instr;
   dec_t              dec;

   // Requests in flight plus buffered words never exceed the queue size.
   assign credit_used    = {1'b0, outstanding} + {1'b0, iq_count};
   assign imem_req_valid = rst_n && !redirect_valid && (credit_used < (CW+1)'(IQ_DEPTH));
   assign imem_req_addr  = pc;

   assign req_fire = imem_req_valid && imem_req_ready;
   assign rsp_drop = imem_rsp_valid && (discard != '0);
   assign rsp_keep = imem_rsp_valid && (discard == '0) && !redirect_valid;
   assign pop      = dec_valid && dec_ready;

   assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
   assign discard_nxt     = discard - CW'(rsp_drop);

   // On redirect every request still in flight belongs to the old stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            pc      <= redirect_pc;
            rsp_pc  <= redirect_pc;
            discard <= outstanding_nxt;
         end else begin
            discard <= discard_nxt;
            if (req_fire) pc     <= pc + ADDR_W'(4);
            if (rsp_keep) rsp_pc <= rsp_pc + ADDR_W'(4);
         end
      end
   end

   instr_queue #(
      .DEPTH  (IQ_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_iq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (redirect_valid),
      .push       (rsp_keep),
      .push_pc    (rsp_pc),
      .push_instr (imem_rsp_data),
      .pop        (pop),
      .empty      (iq_empty),
      .count      (iq_count),
      .head_pc    (head_pc),
      .head_instr (head_instr)
   );

   assign dec_valid = !iq_empty;

   always_comb begin
      dec         = decode(head_instr);
      dec_pc      = '0;
      dec_instr   = '0;
      dec_ra      = '0;
      dec_rb      = '0;
      dec_rw      = '0;
      dec_imm     = '0;
      dec_fmt     = '0;
      dec_illegal = 1'b0;
      if (dec_valid) begin
         dec_pc      = head_pc;
         dec_instr   = head_instr;
         dec_ra      = dec.ra;
         dec_rb      = dec.rb;
         dec_rw      = dec.rw;
         dec_imm     = XLEN'($signed(dec.imm));
         dec_fmt     = dec.fmt;
         dec_illegal = dec.illegal;
      end
   end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench: in-order latency memory model, sequential-stream reference
// with redirect restarts, and literal decode/fill/drop expectations.
module tb_fetch_decode_stage;

   localparam int          XLEN     = 64;
   localparam int          ADDR_W   = 32;
   localparam int          IQ_DEPTH = 8;
   localparam logic [31:0] RST_PC   = 32'h100;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              imem_req_valid, imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid = 1'b0;
   logic [31:0]       imem_rsp_data = '0;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              dec_valid, dec_ready;
   logic [ADDR_W-1:0] dec_pc;
   logic [31:0]       dec_instr;
   logic [4:0]        dec_ra, dec_rb, dec_rw;
   logic [XLEN-1:0]   dec_imm;
   logic [2:0]        dec_fmt;
   logic              dec_illegal;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   mreq_t       mem_q[$];
   int          lat = 1, cyc = 0, q_model = 0, drops = 0, fires = 0;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] exp_pc = RST_PC, req_pc = RST_PC;
   bit          seen_2000, seen_2004, seen_2008, seen_4000;

   always #5 clk = ~clk;

   fetch_decode_stage #(
      .XLEN     (XLEN),
      .ADDR_W   (ADDR_W),
      .RESET_PC (RST_PC),
      .IQ_DEPTH (IQ_DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_pc         (dec_pc),
      .dec_instr      (dec_instr),
      .dec_ra         (dec_ra),
      .dec_rb         (dec_rb),
      .dec_rw         (dec_rw),
      .dec_imm        (dec_imm),
      .dec_fmt        (dec_fmt),
      .dec_illegal    (dec_illegal)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] h;
      logic [6:0]  op;
      if (a == 32'h2000) return 32'hFFF00093;
      if (a == 32'h2004) return 32'h00B50463;
      if (a == 32'h2008) return 32'h0000007F;
      h = a * 32'h9E3779B1;
      case (a[4:2])
         3'd0:    op = 7'b0110011;
         3'd1:    op = 7'b0010011;
         3'd2:    op = 7'b0000011;
         3'd3:    op = 7'b0100011;
         3'd4:    op = 7'b1100011;
         3'd5:    op = 7'b0110111;
         3'd6:    op = 7'b1101111;
         default: op = 7'b1010101;
      endcase
      return {h[31:7], op};
   endfunction

   function automatic logic [63:0] sx(input logic [63:0] v, input int n);
      logic signed [63:0] t;
      t = v << (64 - n);
      return t >>> (64 - n);
   endfunction

   function automatic void ref_dec(input logic [31:0] w, output logic [4:0] ra, output logic [4:0] rb,
                                   output logic [4:0] rw, output logic [63:0] imm,
                                   output logic [2:0] fmt, output logic ill);
      ra = 0; rb = 0; rw = 0; imm = 0; fmt = 0; ill = 0;
      case (w[6:0])
         7'h33:               begin ra = w[19:15]; rb = w[24:20]; rw = w[11:7]; end
         7'h13, 7'h03, 7'h67: begin fmt = 1; ra = w[19:15]; rw = w[11:7]; imm = sx(64'(w[31:20]), 12); end
         7'h23:               begin fmt = 2; ra = w[19:15]; rb = w[24:20]; imm = sx(64'({w[31:25], w[11:7]}), 12); end
         7'h63:               begin fmt = 3; ra = w[19:15]; rb = w[24:20];
                                    imm = sx(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
         7'h37, 7'h17:        begin fmt = 4; rw = w[11:7]; imm = sx(64'({w[31:12], 12'b0}), 32); end
         7'h6F:               begin fmt = 5; rw = w[11:7];
                                    imm = sx(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
         default:             ill = 1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Memory: answers the oldest request once its latency has elapsed.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_at(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEADBEEF;
      end
   end

   // Compare: inputs are stable here, so this sees what the next edge will act on.
   always @(negedge clk) begin : cmp
      logic [4:0]  ra, rb, rw;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      mreq_t       h;
      bit          exp_rv;
      if (!rst_n) begin
         chk("rst_req_valid", imem_req_valid, 0);
         chk("rst_dec_valid", dec_valid, 0);
         chk("rst_dec_pc_instr", {dec_pc, dec_instr}, 0);
         chk("rst_dec_imm", dec_imm, 0);
         mem_q.delete();
         q_model = 0;
         exp_pc  = RST_PC;
         req_pc  = RST_PC;
      end else begin
         exp_rv = !redirect_valid && (mem_q.size() + q_model < IQ_DEPTH);
         chk("req_valid", imem_req_valid, exp_rv);
         if (imem_req_valid) chk("req_addr", imem_req_addr, req_pc);
         chk("dec_valid", dec_valid, q_model != 0);
         if (dec_valid && dec_ready) begin
            ref_dec(word_at(exp_pc), ra, rb, rw, imm, fmt, ill);
            chk("dec_pc", dec_pc, exp_pc);
            chk("dec_instr", dec_instr, word_at(exp_pc));
            chk("dec_regs", {dec_ra, dec_rb, dec_rw}, {ra, rb, rw});
            chk("dec_imm", dec_imm, imm);
            chk("dec_fmt_ill", {dec_fmt, dec_illegal}, {fmt, ill});
            if (exp_pc == 32'h2000) begin
               chk("lit_i_fmt", dec_fmt, 1);
               chk("lit_i_regs", {dec_ra, dec_rw}, {5'd0, 5'd1});
               chk("lit_i_imm", dec_imm, 64'hFFFF_FFFF_FFFF_FFFF);
               seen_2000 = 1;
            end
            if (exp_pc == 32'h2004) begin
               chk("lit_b_fmt", dec_fmt, 3);
               chk("lit_b_regs", {dec_ra, dec_rb, dec_rw}, {5'd10, 5'd11, 5'd0});
               chk("lit_b_imm", dec_imm, 8);
               seen_2004 = 1;
            end
            if (exp_pc == 32'h2008) begin
               chk("lit_illegal", {dec_illegal, dec_fmt}, {1'b1, 3'd0});
               seen_2008 = 1;
            end
            if (exp_pc == 32'h4000) seen_4000 = 1;
            exp_pc += 4;
            q_model--;
         end else if (!dec_valid) begin
            chk("idle_pc_instr", {dec_pc, dec_instr}, 0);
            chk("idle_fields", {dec_ra, dec_rb, dec_rw, dec_fmt, dec_illegal}, 0);
            chk("idle_imm", dec_imm, 0);
         end
         if (imem_rsp_valid && mem_q.size() > 0) begin
            h = mem_q.pop_front();
            if (h.stale || redirect_valid) drops++;
            else q_model++;
         end
         if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat, stale: 1'b0});
            req_pc += 4;
            fires++;
         end
         if (redirect_valid) begin
            exp_pc  = redirect_pc;
            req_pc  = redirect_pc;
            q_model = 0;
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      int snap, f0, d0;
      bit found;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      dec_ready      = 1'b1;

      // Reset, latency 1: two-cycle fill then one instruction per cycle.
      tick(3);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) chk("first_addr", imem_req_addr, 32'h100);
         if (i < 2) chk("fill_dec_valid", dec_valid, 0);
         else begin
            chk("stream_valid", dec_valid, 1);
            chk("stream_pc", dec_pc, 32'h100 + 4 * (i - 2));
         end
      end

      // Consumer stall: fetch stops once the queue's credit is used up.
      tick(1);
      dec_ready = 1'b0;
      snap = mem_q.size() + q_model;
      f0 = fires;
      tick(15);
      @(negedge clk);
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_dec_valid", dec_valid, 1);
      chk("stall_fires", fires - f0, IQ_DEPTH - snap);
      tick(1);
      dec_ready = 1'b1;
      tick(20);

      // Latency 3, redirect with three requests in flight.
      lat = 3;
      tick(10);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (mem_q.size() == 3) found = 1;
         else tick(1);
      end
      chk("three_outstanding", found, 1);
      d0 = drops;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2000;
      tick(1);
      redirect_valid = 1'b0;
      tick(20);
      chk("drop_count_3", drops - d0, 3);
      chk("seen_decode_words", {seen_2000, seen_2004, seen_2008}, 3'b111);

      // Redirect while a response lands and the head is popped, then redirect again.
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (imem_rsp_valid && dec_valid) found = 1;
         else tick(1);
      end
      chk("rsp_pop_setup", found, 1);
      d0 = drops;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3000;
      tick(1);
      redirect_valid = 1'b0;
      chk("flush_dec_valid", dec_valid, 0);
      tick(1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h4000;
      tick(1);
      redirect_valid = 1'b0;
      tick(25);
      chk("drop_count_4", drops - d0, 4);
      chk("seen_4000", seen_4000, 1);

      // Reset with two requests outstanding and three words queued.
      imem_req_ready = 1'b0;
      tick(10);
      dec_ready = 1'b0;
      imem_req_ready = 1'b1;
      tick(5);
      imem_req_ready = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_q.size() == 2 && q_model == 3) found = 1;
         else tick(1);
      end
      chk("reset_setup", found, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_dec_valid", dec_valid, 0);
      chk("async_req_valid", imem_req_valid, 0);
      tick(2);
      rst_n = 1'b1;
      imem_req_ready = 1'b1;
      dec_ready = 1'b1;
      @(negedge clk);
      chk("restart_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
      tick(15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
